// File: rtl/reg_ops_pkg.sv
// Operation codes and shared types for the multi-op register file.
// Imported by the per-word ALU and the register file top level.
package reg_ops_pkg;

   localparam int OP_W = 3;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_NOP     = 3'b000;
   localparam op_t OP_LOAD    = 3'b001;
   localparam op_t OP_INC     = 3'b010;
   localparam op_t OP_DEC     = 3'b011;
   localparam op_t OP_ADD     = 3'b100;
   localparam op_t OP_CLR     = 3'b101;
   localparam op_t OP_CLR_ALL = 3'b110;
   localparam op_t OP_RSVD    = 3'b111;

   // Ops that target exactly one register through wr_addr.
   function automatic logic is_single_op(input op_t op);
      return (op == OP_LOAD) || (op == OP_INC) || (op == OP_DEC) ||
             (op == OP_ADD)  || (op == OP_CLR);
   endfunction

endpackage

// File: rtl/reg_alu_word.sv
// Combinational next-value, carry/borrow and zero computation for one word.
// Arithmetic wraps modulo 2^WIDTH.
module reg_alu_word
   import reg_ops_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] value,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum    = '0;
      result = value;
      carry  = 1'b0;
      case (op)
         OP_LOAD: result = data_in;
         OP_INC: begin
            sum    = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_DEC: begin
            // Borrow only when decrementing from zero.
            result = value - {{(WIDTH-1){1'b0}}, 1'b1};
            carry  = (value == '0);
         end
         OP_ADD: begin
            sum    = {1'b0, value} + {1'b0, data_in};
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_CLR, OP_CLR_ALL: result = '0;
         default: result = value;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/reg_file_multi_op.sv
// Register array with per-cycle arithmetic update ops, two combinational
// read ports (no write bypass) and registered carry/zero/error flags.
module reg_file_multi_op
   import reg_ops_pkg::*;
#(
   parameter  int WIDTH  = 16,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  op_t               op,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  data_in,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_a,
   output logic [WIDTH-1:0]  rd_data_b,
   output logic              carry_out,
   output logic              zero_out,
   output logic              op_err
);

   logic [WIDTH-1:0] regs [DEPTH];

   logic             wr_in_range;
   logic             single_op;
   logic             do_write;
   logic             bad_op;
   logic [WIDTH-1:0] sel_value;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_zero;

   always_comb begin
      wr_in_range = (int'(wr_addr) < DEPTH);
      single_op   = is_single_op(op);
      do_write    = single_op && wr_in_range;
      bad_op      = (op == OP_RSVD) || (single_op && !wr_in_range);
      sel_value   = wr_in_range ? regs[wr_addr] : '0;
   end

   // Out-of-range read addresses return zero rather than aliasing.
   always_comb begin
      rd_data_a = (int'(rd_addr_a) < DEPTH) ? regs[rd_addr_a] : '0;
      rd_data_b = (int'(rd_addr_b) < DEPTH) ? regs[rd_addr_b] : '0;
   end

   reg_alu_word #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op      (op),
      .value   (sel_value),
      .data_in (data_in),
      .result  (alu_result),
      .carry   (alu_carry),
      .zero    (alu_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         carry_out <= 1'b0;
         zero_out  <= 1'b0;
         op_err    <= 1'b0;
      end else begin
         op_err <= bad_op;
         // NOP and erroneous ops leave the registers and both flags untouched.
         if (op == OP_CLR_ALL) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            carry_out <= alu_carry;
            zero_out  <= alu_zero;
         end else if (do_write) begin
            regs[wr_addr] <= alu_result;
            carry_out     <= alu_carry;
            zero_out      <= alu_zero;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_multi_op.sv
// Bench for reg_file_multi_op (DEPTH=6): directed vector table, hand-written
// corner sequences, then random ops checked against a behavioural model.
module tb_reg_file_multi_op;

   localparam int WIDTH = 16;
   localparam int DEPTH = 6;

   logic        clk;
   logic        reset;
   logic [2:0]  op;
   logic [2:0]  wr_addr;
   logic [15:0] data_in;
   logic [2:0]  rd_addr_a;
   logic [2:0]  rd_addr_b;
   logic [15:0] rd_data_a;
   logic [15:0] rd_data_b;
   logic        carry_out;
   logic        zero_out;
   logic        op_err;

   int n_checks = 0;
   int n_errors = 0;

   reg_file_multi_op #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .wr_addr   (wr_addr),
      .data_in   (data_in),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .carry_out (carry_out),
      .zero_out  (zero_out),
      .op_err    (op_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference: plain integer arithmetic on an array of words.
   int unsigned m_reg [DEPTH];
   bit          m_carry, m_zero, m_err;

   function automatic int unsigned model_read(input int a);
      return (a < DEPTH) ? m_reg[a] : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_reg[i] = 0;
      m_carry = 0; m_zero = 0; m_err = 0;
   endtask

   task automatic model_op(input int o, input int a, input int unsigned d);
      int unsigned s;
      if (o == 7 || (o >= 1 && o <= 5 && a >= DEPTH)) begin
         m_err = 1;
      end else begin
         m_err = 0;
         case (o)
            1: begin m_reg[a] = d; m_carry = 0; end
            2: begin s = m_reg[a] + 1; m_carry = (s >= 65536); m_reg[a] = s % 65536; end
            3: begin m_carry = (m_reg[a] == 0); m_reg[a] = (m_reg[a] + 65535) % 65536; end
            4: begin s = m_reg[a] + d; m_carry = (s >= 65536); m_reg[a] = s % 65536; end
            5: begin m_reg[a] = 0; m_carry = 0; end
            6: begin for (int i = 0; i < DEPTH; i++) m_reg[i] = 0; m_carry = 0; end
            default: ;
         endcase
         if (o >= 1 && o <= 5) m_zero = (m_reg[a] == 0);
         if (o == 6) m_zero = 1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive at negedge, commit on posedge, return at the following negedge.
   task automatic cycle(input int o, input int a, input int unsigned d, input int ra, input int rb);
      op        = o[2:0];
      wr_addr   = a[2:0];
      data_in   = d[15:0];
      rd_addr_a = ra[2:0];
      rd_addr_b = rb[2:0];
      @(posedge clk);
      model_op(o, a, d);
      @(negedge clk);
   endtask

   typedef struct {
      int o, wa, d, ra, rb;
      int ea, eb, ec, ez, ee;
   } vec_t;

   function automatic vec_t v(input int o, wa, d, ra, rb, ea, eb, ec, ez, ee);
      vec_t r;
      r.o = o; r.wa = wa; r.d = d; r.ra = ra; r.rb = rb;
      r.ea = ea; r.eb = eb; r.ec = ec; r.ez = ez; r.ee = ee;
      return r;
   endfunction

   vec_t vecs [19];

   initial begin
      int ra, rb, o, a;
      int unsigned d;

      vecs[0]  = v(1, 3, 5,      3, 3, 5,      5, 0, 0, 0);
      vecs[1]  = v(4, 3, 2,      3, 3, 7,      7, 0, 0, 0);
      vecs[2]  = v(1, 0, 'hFFFF, 0, 3, 'hFFFF, 7, 0, 0, 0);
      vecs[3]  = v(2, 0, 0,      0, 3, 0,      7, 1, 1, 0);
      vecs[4]  = v(3, 0, 0,      0, 3, 'hFFFF, 7, 1, 0, 0);
      vecs[5]  = v(2, 0, 0,      0, 3, 0,      7, 1, 1, 0);
      vecs[6]  = v(1, 1, 9,      1, 4, 9,      0, 0, 0, 0);
      vecs[7]  = v(1, 4, 7,      1, 4, 9,      7, 0, 0, 0);
      vecs[8]  = v(5, 1, 0,      1, 4, 0,      7, 0, 1, 0);
      vecs[9]  = v(1, 5, 3,      5, 3, 3,      7, 0, 0, 0);
      vecs[10] = v(6, 2, 0,      5, 3, 0,      0, 0, 1, 0);
      vecs[11] = v(1, 2, 1,      2, 7, 1,      0, 0, 0, 0);
      vecs[12] = v(4, 2, 'hFFFF, 2, 7, 0,      0, 1, 1, 0);
      vecs[13] = v(1, 7, 'hAAAA, 2, 7, 0,      0, 1, 1, 1);
      vecs[14] = v(7, 2, 1,      2, 7, 0,      0, 1, 1, 1);
      vecs[15] = v(0, 2, 1,      2, 7, 0,      0, 1, 1, 0);
      vecs[16] = v(2, 6, 0,      2, 6, 0,      0, 1, 1, 1);
      vecs[17] = v(4, 2, 5,      2, 0, 5,      0, 0, 0, 0);
      vecs[18] = v(3, 1, 0,      1, 2, 'hFFFF, 5, 1, 0, 0);

      // Clock/reset
      reset = 1'b0; op = '0; wr_addr = '0; data_in = '0; rd_addr_a = 3'd2; rd_addr_b = 3'd5;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_rd_a", rd_data_a, 0);
      check("reset_rd_b", rd_data_b, 0);
      check("reset_flags", {carry_out, zero_out, op_err}, 0);
      reset = 1'b1;

      // Directed vector table
      for (int i = 0; i < 19; i++) begin
         cycle(vecs[i].o, vecs[i].wa, vecs[i].d, vecs[i].ra, vecs[i].rb);
         check($sformatf("vec%0d_rd_a", i), rd_data_a, vecs[i].ea);
         check($sformatf("vec%0d_rd_b", i), rd_data_b, vecs[i].eb);
         check($sformatf("vec%0d_carry", i), carry_out, vecs[i].ec);
         check($sformatf("vec%0d_zero", i), zero_out, vecs[i].ez);
         check($sformatf("vec%0d_err", i), op_err, vecs[i].ee);
      end

      // Same-cycle read/write of R2 (currently 5): old value before the edge
      op = 3'd1; wr_addr = 3'd2; data_in = 16'd9; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
      #1;
      check("rw_pre_a", rd_data_a, 5);
      check("rw_pre_b", rd_data_b, 5);
      @(posedge clk);
      model_op(1, 2, 9);
      #1;
      check("rw_post_a", rd_data_a, 9);
      check("rw_post_b", rd_data_b, 9);
      @(negedge clk);

      // Back-to-back INC chains one per edge
      for (int k = 1; k <= 3; k++) begin
         cycle(2, 2, 0, 2, 2);
         check($sformatf("b2b_inc%0d", k), rd_data_a, 9 + k);
      end

      // Asynchronous reset mid-run
      cycle(1, 0, 'hFFFF, 0, 2);
      cycle(1, 2, 'h1234, 2, 0);
      cycle(2, 0, 0, 2, 0);
      cycle(7, 2, 0, 2, 0);
      check("prereset_r2", rd_data_a, 'h1234);
      check("prereset_flags", {carry_out, zero_out, op_err}, 3'b111);
      op = 3'd2; wr_addr = 3'd2;
      #2 reset = 1'b0;
      #1;
      check("async_rd_a", rd_data_a, 0);
      check("async_rd_b", rd_data_b, 0);
      check("async_flags", {carry_out, zero_out, op_err}, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("held_reset_r2", rd_data_a, 0);
      @(posedge clk);
      model_op(2, 2, 0);
      @(negedge clk);
      check("first_edge_r2", rd_data_a, 1);

      // Randomized ops against the model
      for (int n = 0; n < 400; n++) begin
         o  = $urandom_range(0, 7);
         a  = (o == 6) ? $urandom_range(0, 7) : (($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5));
         d  = ($urandom_range(0, 3) == 0) ? 'hFFFF : $urandom_range(0, 'hFFFF);
         ra = $urandom_range(0, 7);
         rb = $urandom_range(0, 7);
         cycle(o, a, d, ra, rb);
         check($sformatf("rnd%0d_rd_a", n), rd_data_a, model_read(ra));
         check($sformatf("rnd%0d_rd_b", n), rd_data_b, model_read(rb));
         check($sformatf("rnd%0d_flags", n), {carry_out, zero_out, op_err}, {m_carry, m_zero, m_err});
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_file_multi_op.md
# reg_file_multi_op

Parametrised multi-register storage block with per-cycle arithmetic update ops (load, increment, decrement, accumulate, clear, clear-all) and two combinational read ports. It replaces single load-enable registers in the matrix-multiplication core. Typical uses are address counters, loop indices and partial-sum accumulators. One instance feeds each processing core's datapath and is driven by the core control unit.

## Interface
- WIDTH, 16, data width of every register
- DEPTH, 8, number of registers (≥2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  input  1  single clock, rising-edge active
- reset  input  1  asynchronous, active-low; clears all state immediately when low
- op  input  3  operation code, sampled on rising clk
- wr_addr  input  ADDR_W  target register for op
- data_in  input  WIDTH  operand for LOAD/ADD
- rd_addr_a  input  ADDR_W  read port A address
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_a  output  WIDTH  contents of register rd_addr_a (combinational)
- rd_data_b  output  WIDTH  contents of register rd_addr_b (combinational)
- carry_out  output  1  registered carry/borrow of last executed arithmetic op
- zero_out  output  1  registered: result of last executed op equals 0
- op_err  output  1  registered: last sampled op was reserved or targeted an out-of-range address

## Operation
- Op codes: 000 NOP, 001 LOAD (R←data_in), 010 INC (R←R+1), 011 DEC (R←R−1), 100 ADD (R←R+data_in), 101 CLR (R←0), 110 CLR_ALL (all R←0), 111 reserved.
- Only register wr_addr changes, except CLR_ALL, which ignores wr_addr.
- Arithmetic is modulo 2^WIDTH (wrap-around, no saturation).
- carry_out:
  - INC/ADD: set to the carry out of bit WIDTH−1.
  - DEC: set to the borrow (1 when R was 0).
  - LOAD/CLR/CLR_ALL: cleared to 0.
  - NOP/reserved: held.
- zero_out:
  - Executed ops: 1 when the written result is 0.
  - CLR_ALL: 1.
  - NOP/reserved: held.
- op_err:
  - Set to 1 for op 111, or for wr_addr ≥ DEPTH on a single-register op.
  - Otherwise 0, including NOP.
  - Erroneous ops change no register and hold carry_out/zero_out.
- Reads:
  - rd_addr ≥ DEPTH returns 0.
  - Both ports may address the same register.
  - No write-to-read bypass: reads show the pre-edge value until the edge commits.

## Timing
- Reset (reset=0) asynchronously forces all registers to 0, carry_out=0, zero_out=0, op_err=0.
- Deassertion takes effect at the first rising clk with reset=1.
- Any op takes effect on the rising edge where it is sampled, giving 1-cycle latency to rd_data and flags.
- Back-to-back ops on the same register chain every cycle (INC on consecutive edges increments by 1 per edge).
- Reset asserted mid-sequence discards the op in flight; no partial update.
- Simultaneous read and write of the same address in one cycle returns the old value that cycle and the new value the next.

## Structure
- Package reg_ops_pkg holds:
  - op-code localparams (OP_NOP … OP_RSVD)
  - the op type/width constant OP_W=3
- Sub-module reg_alu_word: combinational next-value/carry/zero computation for one word from (op, R, data_in).
  - Instantiated once on the selected register's value; the top level handles the register array, address decode, error detection and flag registers.

## Test plan
- Reset: drive reset=0 mid-run after loading R2=16'h1234 → rd_data of R2=0, carry_out=0, zero_out=0, op_err=0 immediately, without waiting for a clk edge.
- Load/read: LOAD R3←16'd5, then ADD R3+16'd2 → rd_data_a(R3)=5, then 7; zero_out=0; carry_out=0.
- Wrap and carry:
  - LOAD R0←16'hFFFF, then INC → R0=0, carry_out=1, zero_out=1.
  - DEC → R0=16'hFFFF, carry_out=1 (borrow).
  - INC again → R0=0, carry_out=1.
- Clear ops: load R1=9 and R4=7, CLR R1 → R1=0, R4=7; then CLR_ALL → all regs 0, zero_out=1, carry_out=0.
- Errors, with DEPTH=6: LOAD wr_addr=7 → op_err=1, no register changes, flags held; op=111 → op_err=1; next NOP → op_err=0; rd_addr=7 reads 0.
- Same-cycle read/write: rd_addr_a=2 while LOAD R2←16'd9 → old value before the edge, 9 after; rd_addr_b=2 shows the identical value.
